// File: rtl/cpu_memory_responder.sv
// Word RAM responder for the accumulator CPU bus with a byte-stream program loader.
// Optional memory-mapped output register enabled by defining MEM_IO_PORT_EN.
module cpu_memory_responder #(
  parameter int          ADDR_BITS = 8,
  parameter logic [15:0] IO_ADDR   = 16'hFFFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [15:0]        address,
  input  logic               we,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_hold,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [7:0]         load_byte,
  output logic               load_ready,
  input  logic               load_end,
  output logic [ADDR_BITS:0] load_count,
  output logic               load_overflow,
  output logic [31:0]        io_out
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_FLUSH, S_RELEASE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS:0]   ptr_q, ptr_d;
  logic [1:0]           bcnt_q, bcnt_d;
  logic [23:0]          asm_q, asm_d;
  logic                 ovf_q, ovf_d;
  logic [31:0]          io_q, io_d;

  logic [31:0]          mem [DEPTH];
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [31:0]          mem_wdata;

  logic                 commit;
  logic [31:0]          commit_word;
  logic                 full;
  logic                 io_hit;

`ifdef MEM_IO_PORT_EN
  assign io_hit = (address == IO_ADDR);
  assign io_out = io_q;
`else
  assign io_hit = 1'b0;
  assign io_out = '0;
`endif

  // Upper address bits and IO_ADDR are intentionally unused in some builds.
  logic unused_ok;
  assign unused_ok = ^{address, IO_ADDR, io_q};

  // Pointer only ever reaches DEPTH, so its top bit means "RAM full".
  assign full          = ptr_q[ADDR_BITS];
  assign load_count    = ptr_q;
  assign load_overflow = ovf_q;

  assign cpu_rdata = io_hit ? io_q : mem[address[ADDR_BITS-1:0]];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    bcnt_d      = bcnt_q;
    asm_d       = asm_q;
    ovf_d       = ovf_q;
    io_d        = io_q;
    cpu_hold    = 1'b1;
    load_ready  = 1'b0;
    commit      = 1'b0;
    commit_word = '0;
    mem_we      = 1'b0;
    mem_waddr   = address[ADDR_BITS-1:0];
    mem_wdata   = cpu_wdata;

    unique case (state_q)
      S_IDLE: begin
        cpu_hold = 1'b0;
        if (we) begin
          if (io_hit) io_d = cpu_wdata;
          else        mem_we = 1'b1;
        end
        if (load_start) begin
          state_d = S_RECV;
          ptr_d   = '0;
          bcnt_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      S_RECV: begin
        load_ready = 1'b1;
        if (load_valid) begin
          asm_d = {asm_q[15:0], load_byte};
          if (bcnt_q == 2'd3) begin
            commit      = 1'b1;
            commit_word = {asm_q, load_byte};
            bcnt_d      = '0;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
        // End is judged after this cycle's byte has been absorbed.
        if (load_end) state_d = (bcnt_d != 2'd0) ? S_FLUSH : S_RELEASE;
      end
      S_FLUSH: begin
        commit = 1'b1;
        unique case (bcnt_q)
          2'd1:    commit_word = {asm_q[7:0],  24'h0};
          2'd2:    commit_word = {asm_q[15:0], 16'h0};
          default: commit_word = {asm_q[23:0], 8'h0};
        endcase
        bcnt_d  = '0;
        state_d = S_RELEASE;
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q[ADDR_BITS-1:0];
        mem_wdata = commit_word;
        ptr_d     = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
      io_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      io_q    <= io_d;
    end
  end

  // RAM has no reset; contents survive a reset mid-load.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_cpu_memory_responder.sv
// Directed bench for cpu_memory_responder: an 8-bit-index instance and a 2-bit-index
// instance share stimulus; read expectations flow through a scoreboard queue.
module tb_cpu_memory_responder;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, we, load_start, load_valid, load_end;
  logic [15:0] address;
  logic [31:0] cpu_wdata;
  logic [7:0]  load_byte;

  logic [31:0] a_rdata, a_io, b_rdata, b_io;
  logic        a_hold, a_ready, a_ovf, b_hold, b_ready, b_ovf;
  logic [8:0]  a_count;
  logic [2:0]  b_count;

  cpu_memory_responder #(.ADDR_BITS(8)) dut_a (
    .clock(clock), .reset(reset), .address(address), .we(we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_rdata), .cpu_hold(a_hold), .load_start(load_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_ready(a_ready), .load_end(load_end), .load_count(a_count),
    .load_overflow(a_ovf), .io_out(a_io));

  cpu_memory_responder #(.ADDR_BITS(2)) dut_b (
    .clock(clock), .reset(reset), .address(address), .we(we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_rdata), .cpu_hold(b_hold), .load_start(load_start), .load_valid(load_valid),
    .load_byte(load_byte), .load_ready(b_ready), .load_end(load_end), .load_count(b_count),
    .load_overflow(b_ovf), .io_out(b_io));

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input bit sel_b, input string tag, input logic [15:0] a, input logic [31:0] exp);
    exp_t e;
    sb.push_back('{tag, exp});
    address = a;
    #1;
    e = sb.pop_front();
    chk(e.tag, sel_b ? b_rdata : a_rdata, e.exp);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit last);
    load_valid = 1'b1;
    load_byte  = b;
    load_end   = last;
    tick();
    load_valid = 1'b0;
    load_end   = 1'b0;
  endtask

  task automatic end_load();
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [31:0] d);
    address   = a;
    cpu_wdata = d;
    we        = 1'b1;
    tick();
    we        = 1'b0;
  endtask

  function automatic logic [31:0] ovf_word(input int k);
    return {8'(k*4+1), 8'(k*4+2), 8'(k*4+3), 8'(k*4+4)};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  idx, up;
    logic [31:0] w;

    reset = 1'b1; we = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0;
    address = '0; cpu_wdata = '0; load_byte = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_hold",  32'(a_hold),  0);
    chk("rst_ready", 32'(a_ready), 0);
    chk("rst_count", 32'(a_count), 0);
    chk("rst_ovf",   32'(a_ovf),   0);
    chk("rst_io",    a_io,         0);
    chk("rst_b_cnt", 32'(b_count), 0);

    // single full word, end in its own cycle
    start_load();
    chk("t1_hold_recv",  32'(a_hold),  1);
    chk("t1_ready_recv", 32'(a_ready), 1);
    send(8'h40, 0); send(8'h00, 0); send(8'h00, 0); send(8'h05, 0);
    chk("t1_count", 32'(a_count), 1);
    end_load();
    chk("t1_hold_release",  32'(a_hold),  1);
    chk("t1_ready_release", 32'(a_ready), 0);
    tick();
    chk("t1_hold_idle", 32'(a_hold), 0);
    rd(0, "t1_mem0", 16'h0000, 32'h40000005);
    chk("t1_ovf", 32'(a_ovf), 0);

    // partial word needs a flush
    start_load();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    send(8'h44, 0); send(8'h55, 0); send(8'h66, 0);
    chk("t2_count_pre", 32'(a_count), 1);
    end_load();
    chk("t2_hold_flush",  32'(a_hold),  1);
    chk("t2_ready_flush", 32'(a_ready), 0);
    tick();
    chk("t2_hold_release", 32'(a_hold), 1);
    chk("t2_count", 32'(a_count), 2);
    tick();
    chk("t2_hold_idle", 32'(a_hold), 0);
    rd(0, "t2_mem0", 16'h0000, 32'h11223344);
    rd(0, "t2_mem1", 16'h0001, 32'h55660000);

    // last byte and end in the same cycle skip the flush
    start_load();
    send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 1);
    chk("t3_hold_release",  32'(a_hold),  1);
    chk("t3_ready_release", 32'(a_ready), 0);
    chk("t3_count", 32'(a_count), 1);
    tick();
    chk("t3_hold_idle", 32'(a_hold), 0);
    rd(0, "t3_mem0", 16'h0000, 32'hA1A2A3A4);
    rd(0, "t3_mem1", 16'h0001, 32'h55660000);

    // CPU write aliasing, and writes ignored while loading
    cpu_write(16'h0103, 32'hDEADBEEF);
    rd(0, "t4_alias_a", 16'h0003, 32'hDEADBEEF);
    rd(1, "t4_alias_b", 16'h0003, 32'hDEADBEEF);
    address = 16'h0000;
    start_load();
    cpu_write(16'h0003, 32'h12345678);
    end_load();
    chk("t4_empty_count", 32'(a_count), 0);
    tick();
    rd(0, "t4_recv_write", 16'h0003, 32'hDEADBEEF);

    // random write then next-cycle read
    for (int i = 0; i < 6; i++) begin
      idx = 8'($urandom_range(16, 200));
      up  = 8'($urandom_range(0, 254));
      w   = $urandom;
      cpu_write({up, idx}, w);
      rd(0, "t5_rand", {8'h00, idx}, w);
    end

    // overflow: five words into a four-word RAM
    address = 16'h0000;
    start_load();
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 4; j++) send(8'(k*4+j+1), 0);
    chk("t6_b_count", 32'(b_count), 4);
    chk("t6_b_ovf",   32'(b_ovf),   1);
    chk("t6_a_count", 32'(a_count), 5);
    chk("t6_a_ovf",   32'(a_ovf),   0);
    end_load();
    tick();
    chk("t6_b_ovf_sticky", 32'(b_ovf), 1);
    for (int k = 0; k < 4; k++) rd(1, "t6_b_mem", 16'(k), ovf_word(k));
    rd(0, "t6_a_mem4", 16'h0004, ovf_word(4));
    address = 16'h0000;
    start_load();
    chk("t6_ovf_clear", 32'(b_ovf),   0);
    chk("t6_cnt_clear", 32'(b_count), 0);

    // reset in the middle of the second word
    send(8'hF0, 0); send(8'hF1, 0); send(8'hF2, 0); send(8'hF3, 0);
    send(8'hF4, 0); send(8'hF5, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_hold",   32'(a_hold),  0);
    chk("t7_ready",  32'(a_ready), 0);
    chk("t7_count",  32'(a_count), 0);
    chk("t7_b_hold", 32'(b_hold),  0);
    rd(0, "t7_mem0", 16'h0000, 32'hF0F1F2F3);
    rd(0, "t7_mem1", 16'h0001, ovf_word(1));

    // output register at the top of the address space
    cpu_write(16'h00FF, 32'h77777777);
    cpu_write(16'hFFFF, 32'h000000A5);
`ifdef MEM_IO_PORT_EN
    chk("t8_io", a_io, 32'h000000A5);
    rd(0, "t8_io_rd",  16'hFFFF, 32'h000000A5);
    rd(0, "t8_mem_ff", 16'h00FF, 32'h77777777);
`else
    chk("t8_io", a_io, 32'h0);
    rd(0, "t8_alias_ff", 16'h00FF, 32'h000000A5);
    rd(0, "t8_alias_rd", 16'hFFFF, 32'h000000A5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_memory_responder.md
Name: cpu_memory_responder

Overview:
- Memory-side responder for the single-accumulator CPU bus: `address[15:0]`, `we`, 32-bit write data, 32-bit read data.
- Serves instruction fetches, loads and stores from an internal word RAM.
- Contains a byte-stream program loader. The loader fills the RAM while holding the CPU in reset, then releases it.
- Sits between the CPU and the board-level program download path.

Parameters:
- ADDR_BITS, 8, RAM index width. Depth = 2**ADDR_BITS words of 32 bits.
- IO_ADDR, 16'hFFFF, bus address of the memory-mapped output register. Used only with MEM_IO_PORT_EN.

Ports:
- clock  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- address  in  16  CPU bus address
- we  in  1  CPU write enable
- cpu_wdata  in  32  CPU store data (the CPU's data_out)
- cpu_rdata  out  32  read data to the CPU (the CPU's data_in)
- cpu_hold  out  1  drive into the CPU reset; high while loading
- load_start  in  1  single-cycle pulse, begin a program load
- load_valid  in  1  load_byte is valid this cycle
- load_byte  in  8  program byte, big-endian within each word
- load_ready  out  1  responder accepts a byte this cycle
- load_end  in  1  single-cycle pulse, end of program stream
- load_count  out  ADDR_BITS+1  words written by the current or last load
- load_overflow  out  1  sticky: bytes were dropped because the RAM was full
- io_out  out  32  memory-mapped output register

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE.
  - Byte count, word pointer and load_count = 0.
  - cpu_hold = 0, load_ready = 0, load_overflow = 0, io_out = 0.
  - RAM contents are not cleared.
- Reads:
  - Combinational, zero latency: cpu_rdata = mem[address[ADDR_BITS-1:0]] in the same cycle.
  - The CPU samples data_in on the same edge at which it presents the address.
  - Upper address bits are ignored, so addresses alias modulo depth.
- CPU writes:
  - On posedge, if we && state==IDLE: mem[address[ADDR_BITS-1:0]] <= cpu_wdata.
  - A write followed by a read of the same address returns the new data on the next cycle.
  - CPU writes are ignored in every non-IDLE state.
- FSM states:
  - IDLE: cpu_hold=0, load_ready=0.
    - load_start -> RECV. Clear pointer, byte count, load_count and load_overflow.
  - RECV: cpu_hold=1, load_ready=1.
    - Each load_valid shifts load_byte into the assembly register; the first byte lands in [31:24].
    - On the 4th byte, the assembled word is written to mem[pointer] at that same edge. Then pointer++, load_count++, byte count=0.
    - load_end -> FLUSH if byte count != 0 after this cycle's byte, else -> RELEASE.
  - FLUSH: cpu_hold=1, load_ready=0.
    - Writes the partial word with the missing low bytes zero-filled. pointer++, load_count++.
    - -> RELEASE.
  - RELEASE: cpu_hold=1 for exactly this one cycle, so the CPU sees reset on a final edge and restarts at PC=0.
    - -> IDLE.
- Simultaneous load_valid and load_end in RECV: the byte is accepted first, then the end is evaluated.
- load_start outside IDLE is ignored.
- load_valid outside RECV is ignored; there is no buffering.
- Full RAM: when pointer == depth, completed words are discarded. load_overflow sets and stays high until the next load_start. load_count saturates at depth.
- Reset mid-load:
  - Immediately returns to IDLE and releases cpu_hold.
  - Words already written remain in the RAM.
  - Partially assembled bytes are lost.
- Load latency: last byte to cpu_hold low is 2 cycles when no flush is needed (RELEASE, IDLE), 3 cycles with a flush.

Optional Feature:
- MEM_IO_PORT_EN defined:
  - A bus address equal to IO_ADDR (full 16-bit compare) maps to io_out instead of the RAM.
  - IDLE write latches io_out <= cpu_wdata; the RAM is unaffected.
  - A read at IO_ADDR returns io_out.
  - The loader never touches io_out.
- Not defined:
  - io_out is tied to 0.
  - IO_ADDR aliases into the RAM like any other address.

Test Plan:
- Reset, then load_start; bytes 8'h40,8'h00,8'h00,8'h05 then load_end -> mem[0]=32'h40000005, load_count=1; cpu_hold high from the edge after load_start and low 2 cycles after load_end; load_overflow=0.
- Load 6 bytes 11,22,33,44,55,66 then load_end -> mem[0]=32'h11223344, mem[1]=32'h55660000 via FLUSH, load_count=2.
- In IDLE, we=1, address=16'h0103, cpu_wdata=32'hDEADBEEF with ADDR_BITS=8 -> the next-cycle read of 16'h0003 returns DEADBEEF; the same write during RECV leaves the RAM unchanged.
- ADDR_BITS=2; load 5 full words -> words 0-3 stored, 5th dropped, load_overflow=1, load_count=4; next load_start clears load_overflow.
- Assert reset after 2 bytes of the second word -> state IDLE, cpu_hold=0 that cycle, mem[0] retains the first word.
- With MEM_IO_PORT_EN: write 32'h000000A5 to 16'hFFFF -> io_out=32'hA5, read of FFFF returns A5, mem[8'hFF] unchanged.
